reg_wb_unit: RTL and testbench

- Write-side driver of the core's 32x32 integer register file.
- Merges two result sources into the single register-file write port (rda/rd/rdw):
  - in-order ALU results;
  - returning memory load data.
- Keeps a load-destination scoreboard so decode can stall on RAW/WAW hazards against outstanding loads.
- Sits between execute/LSU and the register file.

---
 rtl/reg_wb_pkg.sv | 14 +
 rtl/reg_wb_unit_fifo.sv | 60 ++++++
 rtl/reg_wb_unit.sv | 126 ++++++++++++
 tb/tb_reg_wb_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared widths and helpers for the register-file write-back unit.
package reg_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // 5-to-32 one-hot decode of a register address
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        reg_onehot    = '0;
        reg_onehot[a] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_wb_unit_fifo.sv
// Small synchronous FIFO with simultaneous push/pop and full/empty flags.
// Also exposes raw storage and a per-slot valid mask so the owner can
// scan every live entry (used for the load scoreboard).
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              wdata,
    output logic [W-1:0]              rdata,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0][W-1:0]   entries,
    output logic [DEPTH-1:0]          vld
);

    // Pointer width kept at least 1 so DEPTH=1 still elaborates.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign entries = mem;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; validity comes from the pointers alone
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // A slot is live when its distance from the read pointer is below count
    always_comb begin
        vld = '0;
        for (int i = 0; i < DEPTH; i++)
            vld[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count);
    end

endmodule

// File: rtl/reg_wb_unit.sv
// Register-file write-back: merges load returns and ALU results into the
// single write port and tracks outstanding load destinations for decode.
module reg_wb_unit
    import reg_wb_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int LD_DEPTH       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rda,
    input  logic [XLEN-1:0]       alu_rd,
    output logic                  alu_ready,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_rda,
    output logic                  ld_issue_ready,
    input  logic                  ld_valid,
    input  logic [XLEN-1:0]       ld_data,
    output logic [REG_ADDR_W-1:0] rda,
    output logic [XLEN-1:0]       rd,
    output logic                  rdw,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  wb_err
);

    localparam int AW_W = REG_ADDR_W + XLEN;

    logic                                       alu_full, alu_empty, ld_full, ld_empty;
    logic [AW_W-1:0]                            alu_head;
    logic [REG_ADDR_W-1:0]                      ld_head;
    logic [LD_DEPTH-1:0][REG_ADDR_W-1:0]        ld_ents;
    logic [LD_DEPTH-1:0]                        ld_vld;
    logic [ALU_FIFO_DEPTH-1:0][AW_W-1:0]        alu_ents_unused;
    logic [ALU_FIFO_DEPTH-1:0]                  alu_vld_unused;

    logic alu_acc, alu_push, alu_pop, bypass, ld_push, ld_pop;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_a;
    logic [XLEN-1:0]       wr_d;
    logic [NUM_REGS-1:0]   busy_c;

    // Ready depends only on registered occupancy, never on ld_valid
    assign alu_ready      = ~alu_full;
    assign ld_issue_ready = ~ld_full;

    // Load return wins; ALU backlog drains before a fresh result may bypass
    assign alu_acc  = alu_valid & ~alu_full;
    assign ld_pop   = ld_valid & ~ld_empty;
    assign alu_pop  = ~ld_valid & ~alu_empty;
    assign bypass   = ~ld_valid & alu_empty & alu_acc;
    assign alu_push = alu_acc & ~bypass;
    assign ld_push  = ld_issue & ~ld_full;

    wb_fifo #(.W(AW_W), .DEPTH(ALU_FIFO_DEPTH)) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (alu_push),
        .pop     (alu_pop),
        .wdata   ({alu_rda, alu_rd}),
        .rdata   (alu_head),
        .full    (alu_full),
        .empty   (alu_empty),
        .entries (alu_ents_unused),
        .vld     (alu_vld_unused)
    );

    wb_fifo #(.W(REG_ADDR_W), .DEPTH(LD_DEPTH)) u_ld_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ld_push),
        .pop     (ld_pop),
        .wdata   (ld_rda),
        .rdata   (ld_head),
        .full    (ld_full),
        .empty   (ld_empty),
        .entries (ld_ents),
        .vld     (ld_vld)
    );

    // Select the single write for this cycle
    always_comb begin
        wr_en = 1'b0;
        wr_a  = '0;
        wr_d  = '0;
        if (ld_pop) begin
            wr_en = 1'b1;
            wr_a  = ld_head;
            wr_d  = ld_data;
        end else if (alu_pop) begin
            wr_en = 1'b1;
            {wr_a, wr_d} = alu_head;
        end else if (bypass) begin
            wr_en = 1'b1;
            wr_a  = alu_rda;
            wr_d  = alu_rd;
        end
    end

    // Registered write port and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdw    <= 1'b0;
            rda    <= '0;
            rd     <= '0;
            wb_err <= 1'b0;
        end else begin
            // x0 writes are consumed but never reach the register file
            rdw <= wr_en & (wr_a != '0);
            if (wr_en) begin
                rda <= wr_a;
                rd  <= wr_d;
            end
            wb_err <= wb_err | (ld_issue & ld_full) | (ld_valid & ld_empty);
        end
    end

    // Scoreboard: union of every live load destination, x0 masked off
    always_comb begin
        busy_c = '0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (ld_vld[i]) busy_c = busy_c | reg_onehot(ld_ents[i]);
        busy = busy_c & ~NUM_REGS'(1);
    end

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed bench for reg_wb_unit: bypass, load priority, FIFO backpressure,
// scoreboard overlap, x0 handling, protocol errors and mid-flight reset.
module tb_reg_wb_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rda;
    logic [31:0] alu_rd;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rda;
    logic        ld_issue_ready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  rda;
    logic [31:0] rd;
    logic        rdw;
    logic [31:0] busy;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_wb_unit #(.ALU_FIFO_DEPTH(2), .LD_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_rda        (alu_rda),
        .alu_rd         (alu_rd),
        .alu_ready      (alu_ready),
        .ld_issue       (ld_issue),
        .ld_rda         (ld_rda),
        .ld_issue_ready (ld_issue_ready),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .rda            (rda),
        .rd             (rd),
        .rdw            (rdw),
        .busy           (busy),
        .wb_err         (wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rda = '0; alu_rd = '0;
        ld_issue  = 1'b0; ld_rda  = '0;
        ld_valid  = 1'b0; ld_data = '0;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".rdw"}, 32'(rdw), 32'd1);
        chk({tag, ".rda"}, 32'(rda), 32'(a));
        chk({tag, ".rd"},  rd, d);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        // Reset state
        chk("rst.rdw",   32'(rdw), 0);
        chk("rst.rda",   32'(rda), 0);
        chk("rst.rd",    rd, 0);
        chk("rst.err",   32'(wb_err), 0);
        chk("rst.busy",  busy, 0);
        chk("rst.ardy",  32'(alu_ready), 1);
        chk("rst.lrdy",  32'(ld_issue_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU bypass: latency 1, single-cycle rdw
        alu_valid = 1'b1; alu_rda = 5'd5; alu_rd = 32'hDEADBEEF;
        tick(); idle();
        chk_wr("byp", 5'd5, 32'hDEADBEEF);
        tick();
        chk("byp.off", 32'(rdw), 0);

        // Load priority over a concurrent ALU result
        ld_issue = 1'b1; ld_rda = 5'd7;
        tick(); idle();
        chk("pri.busy0", busy, 32'h0000_0080);
        tick();
        chk("pri.busy1", busy, 32'h0000_0080);
        ld_valid = 1'b1; ld_data = 32'h11;
        alu_valid = 1'b1; alu_rda = 5'd3; alu_rd = 32'h22;
        tick(); idle();
        chk_wr("pri.ld", 5'd7, 32'h11);
        chk("pri.busy2", busy, 0);
        tick();
        chk_wr("pri.alu", 5'd3, 32'h22);
        tick();
        chk("pri.off", 32'(rdw), 0);

        // FIFO full: three loads return back-to-back while ALU offers three
        for (int i = 0; i < 3; i++) begin
            ld_issue = 1'b1; ld_rda = 5'(8 + i);
            tick();
        end
        idle();
        chk("full.busy", busy, 32'h0000_0700);
        ld_valid = 1'b1; ld_data = 32'h80; alu_valid = 1'b1; alu_rda = 5'd20; alu_rd = 32'hA20;
        tick();
        chk_wr("full.ld8", 5'd8, 32'h80);
        chk("full.rdy1", 32'(alu_ready), 1);
        ld_data = 32'h90; alu_rda = 5'd21; alu_rd = 32'hA21;
        tick();
        chk_wr("full.ld9", 5'd9, 32'h90);
        chk("full.rdy2", 32'(alu_ready), 0);
        ld_data = 32'hA0; alu_rda = 5'd22; alu_rd = 32'hA22;
        tick();
        chk_wr("full.ld10", 5'd10, 32'hA0);
        chk("full.rdy3", 32'(alu_ready), 0);
        chk("full.busy0", busy, 0);
        ld_valid = 1'b0; ld_data = '0;
        tick();
        chk_wr("full.a20", 5'd20, 32'hA20);
        chk("full.rdy4", 32'(alu_ready), 1);
        tick(); idle();
        chk_wr("full.a21", 5'd21, 32'hA21);
        tick();
        chk_wr("full.a22", 5'd22, 32'hA22);
        tick();
        chk("full.off", 32'(rdw), 0);
        chk("full.rdy5", 32'(alu_ready), 1);

        // Scoreboard overlap on x12
        ld_issue = 1'b1; ld_rda = 5'd12;
        tick(); tick(); idle();
        chk("ovl.busy0", busy, 32'h0000_1000);
        ld_valid = 1'b1; ld_data = 32'h1;
        tick(); idle();
        chk_wr("ovl.r1", 5'd12, 32'h1);
        chk("ovl.busy1", busy, 32'h0000_1000);
        ld_valid = 1'b1; ld_data = 32'h2;
        tick(); idle();
        chk_wr("ovl.r2", 5'd12, 32'h2);
        chk("ovl.busy2", busy, 0);

        // x0 destinations: consumed, never written, never busy
        ld_issue = 1'b1; ld_rda = 5'd0;
        tick(); idle();
        chk("x0.busy", busy, 0);
        chk("x0.rdy", 32'(ld_issue_ready), 1);
        ld_valid = 1'b1; ld_data = 32'h55;
        tick(); idle();
        chk("x0.ld.rdw", 32'(rdw), 0);
        chk("x0.err", 32'(wb_err), 0);
        alu_valid = 1'b1; alu_rda = 5'd0; alu_rd = 32'h66;
        tick(); idle();
        chk("x0.alu.rdw", 32'(rdw), 0);

        // Load return with empty queue
        ld_valid = 1'b1; ld_data = 32'h77;
        tick(); idle();
        chk("emp.rdw", 32'(rdw), 0);
        chk("emp.err", 32'(wb_err), 1);
        tick(); tick();
        chk("emp.sticky", 32'(wb_err), 1);

        // Reset mid-operation: loads x15,x16,x17 queued, two ALU results buffered
        for (int i = 0; i < 3; i++) begin
            ld_issue = 1'b1; ld_rda = 5'(15 + i);
            tick();
        end
        idle();
        ld_valid = 1'b1; ld_data = 32'hF15; alu_valid = 1'b1; alu_rda = 5'd1; alu_rd = 32'hB1;
        tick();
        ld_data = 32'hF16; alu_rda = 5'd2; alu_rd = 32'hB2;
        tick(); idle();
        chk_wr("mid.ld16", 5'd16, 32'hF16);
        chk("mid.busy", busy, 32'h0002_0000);
        chk("mid.rdy", 32'(alu_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rdw", 32'(rdw), 0);
        chk("mid.busy0", busy, 0);
        chk("mid.err", 32'(wb_err), 0);
        tick(); tick();
        rst_n = 1'b1;
        chk("mid.ardy", 32'(alu_ready), 1);
        chk("mid.lrdy", 32'(ld_issue_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid.stale", 32'(rdw), 0);
        end

        // Issue while load queue full
        for (int i = 0; i < 4; i++) begin
            ld_issue = 1'b1; ld_rda = 5'(24 + i);
            tick();
        end
        idle();
        chk("ovf.rdy", 32'(ld_issue_ready), 0);
        chk("ovf.err0", 32'(wb_err), 0);
        ld_issue = 1'b1; ld_rda = 5'd30;
        tick(); idle();
        chk("ovf.err1", 32'(wb_err), 1);
        chk("ovf.busy", busy, 32'h0F00_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
